xbar_route_scheduler: RTL and testbench
=======================================

# xbar_route_scheduler

Control-side master for the packet-routing crossbar: it holds a small programmable schedule of routes and drives the crossbar's `control`/`control_val`/`control_rdy` port. Each schedule entry is one route, given as an input index, an output index and a burst length. On `start` the block issues each entry's control word in order. It then counts completed beats on the routed path and moves to the next entry after the burst finishes. It sits beside the crossbar in the interconnect top level and replaces ad-hoc control driving from the testbench or host.

## Interface
- `N_INPUTS`, 2: crossbar input count; `ISEL_W = $clog2(N_INPUTS)`
- `N_OUTPUTS`, 2: crossbar output count; `OSEL_W = $clog2(N_OUTPUTS)`
- `CONTROL_BIT_WIDTH`, 42: crossbar control word width
- `N_ENTRIES`, 4: schedule depth
- `BURST_WIDTH`, 8: burst-length field width
- `clk`  input  1  clock; all state updates on its rising edge
- `reset`  input  1  asynchronous, active-low reset
- `cfg_msg`  input  ISEL_W+OSEL_W+BURST_WIDTH  entry as {in_sel, out_sel, burst}
- `cfg_val`  input  1  entry valid
- `cfg_rdy`  output  1  entry accepted when `cfg_val & cfg_rdy`
- `clr`  input  1  empties the schedule (acted on in IDLE only)
- `start`  input  1  starts one pass over the loaded entries (acted on in IDLE only)
- `busy`  output  1  high when state is not IDLE
- `done`  output  1  one-cycle pulse at the end of a pass
- `control`  output  CONTROL_BIT_WIDTH  crossbar control word
- `control_val`  output  1  control word valid
- `control_rdy`  input  1  crossbar ready for a control word
- `xfer_fire`  input  1  one completed beat (val & rdy) on the currently routed crossbar output

## Operation
- Control word layout: `control[CBW-1 -: ISEL_W] = in_sel`, `control[CBW-1-ISEL_W -: OSEL_W] = out_sel`; all remaining bits are 0.
- Out-of-range `in_sel`/`out_sel` values are forwarded unchanged. Keeping them in range is the loader's responsibility.
- Schedule storage:
  - Entries are written at index `n_loaded`, which then increments.
  - `cfg_rdy = (state==IDLE) && (n_loaded < N_ENTRIES)`.
  - `clr` in IDLE sets `n_loaded` to 0. If `clr` and `cfg_val` occur in the same cycle, `clr` wins and the entry is dropped.
  - The schedule survives a pass, so a later `start` replays it.
- FSM states: IDLE, ISSUE, COUNT.
  - IDLE, `start`, `n_loaded==0`: stay in IDLE; `done` pulses next cycle.
  - IDLE, `start`, otherwise: `idx` becomes the first entry with `burst!=0`. If no such entry exists, behave as the empty case. Otherwise go to ISSUE.
  - ISSUE: `control_val=1`, `control` holds entry `idx`. When `control_rdy` is high, go to COUNT and set `beat_cnt=0`.
  - COUNT: each `xfer_fire` increments `beat_cnt`. When a fire makes `beat_cnt == burst`:
    - If there is a next entry with `burst!=0`, go to ISSUE for that entry.
    - Otherwise go to IDLE with `done=1` for one cycle.
- Entries with `burst==0` are skipped and produce no control word.
- `xfer_fire` is ignored outside COUNT.
- `start` and `clr` are ignored while `busy`.
- `beat_cnt` is BURST_WIDTH bits, so the maximum burst is 2^BURST_WIDTH−1.

## Timing
- Reset values: `control=0`, `control_val=0`, `busy=0`, `done=0`, `cfg_rdy=1`, `n_loaded=0`, state IDLE.
- Asserting `reset` mid-pass aborts the pass immediately and clears the schedule.
- `control` and `control_val` are registered outputs. `control` is stable while `control_val` is high.
- `start` at edge t makes `control_val` high in cycle t+1. The handshake completes at the first edge where `control_rdy` is high.
- The crossbar latches the word at that edge, so beats counted from the next cycle onward belong to the new route.
- Last beat at edge t:
  - The next control word is valid in cycle t+1. The minimum gap between routes is 1 cycle in ISSUE.
  - If the pass is finished, `done` and `busy=0` are both seen in cycle t+1.
- `cfg_rdy` is combinational from state and `n_loaded`.

## Structure
- Package `xbar_sched_pkg` holds:
  - the state enum;
  - `ISEL_W`, `OSEL_W` and the entry-width localparams;
  - a `pack_control(in_sel, out_sel)` function that returns a CONTROL_BIT_WIDTH word.
- Sub-module `xbar_sched_table`: an N_ENTRIES register file with write port, `n_loaded` counter and `clr`, plus a combinational read at `idx`.
- The next-nonzero-entry search stays in the top-level module.

## Test plan
- Load {in 1, out 0, burst 3}, then `start`: control word 0x200_0000_0000 (bit 41 set) is issued once, `busy` stays high for exactly 3 `xfer_fire` pulses, then `done` pulses and `busy=0`.
- Hold `control_rdy=0` for 5 cycles during ISSUE: `control_val` and `control` stay constant, and `xfer_fire` pulses in that window are not counted.
- Load 4 entries with bursts {2, 0, 1, 3}, `start`: exactly three control words are issued in order, and the total beat count before `done` is 6.
- Fill the schedule to N_ENTRIES: `cfg_rdy` drops to 0 and a 5th `cfg_val` is not stored. `clr` followed by `start` yields a `done` pulse in the next cycle with no control issued.
- Pull `reset` low in the middle of COUNT: `control_val`, `busy` and `done` go to 0 at once, and `cfg_rdy` is 1 after release.
- `start` and `clr` while `busy`, and `cfg_val` while `busy`: all are ignored and the pass completes unchanged.

Source files
------------

// File: rtl/xbar_sched_pkg.sv
// Shared widths, state encoding, schedule entry layout and control-word packing
// for the crossbar route scheduler.
package xbar_sched_pkg;

  localparam int unsigned N_INPUTS          = 2;
  localparam int unsigned N_OUTPUTS         = 2;
  localparam int unsigned CONTROL_BIT_WIDTH = 42;
  localparam int unsigned N_ENTRIES         = 4;
  localparam int unsigned BURST_WIDTH       = 8;

  localparam int unsigned ISEL_W  = $clog2(N_INPUTS);
  localparam int unsigned OSEL_W  = $clog2(N_OUTPUTS);
  localparam int unsigned ENTRY_W = ISEL_W + OSEL_W + BURST_WIDTH;
  localparam int unsigned IDX_W   = $clog2(N_ENTRIES);
  localparam int unsigned CNT_W   = $clog2(N_ENTRIES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ISEL_W-1:0]      in_sel;
    logic [OSEL_W-1:0]      out_sel;
    logic [BURST_WIDTH-1:0] burst;
  } entry_t;

  // Selects sit in the top bits of the word; everything below is zero.
  function automatic logic [CONTROL_BIT_WIDTH-1:0] pack_control(
    input logic [ISEL_W-1:0] in_sel,
    input logic [OSEL_W-1:0] out_sel
  );
    logic [CONTROL_BIT_WIDTH-1:0] w;
    w = '0;
    w[CONTROL_BIT_WIDTH-1 -: ISEL_W]        = in_sel;
    w[CONTROL_BIT_WIDTH-1-ISEL_W -: OSEL_W] = out_sel;
    return w;
  endfunction

endpackage

// File: rtl/xbar_sched_table.sv
// Schedule register file: append-only write port, fill counter, clear,
// combinational read and a per-entry "loaded and non-zero burst" mask.
module xbar_sched_table
  import xbar_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  entry_t               wr_data,
  input  logic                 clr,
  input  logic [IDX_W-1:0]     rd_idx,
  output entry_t               rd_data,
  output logic [CNT_W-1:0]     n_loaded,
  output logic [N_ENTRIES-1:0] nz_mask
);

  entry_t mem [N_ENTRIES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_loaded <= '0;
      for (int i = 0; i < int'(N_ENTRIES); i++) mem[i] <= '0;
    end else if (clr) begin
      n_loaded <= '0;
    end else if (wr_en && (n_loaded < CNT_W'(N_ENTRIES))) begin
      mem[n_loaded[IDX_W-1:0]] <= wr_data;
      n_loaded                 <= n_loaded + CNT_W'(1);
    end
  end

  assign rd_data = mem[rd_idx];

  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++)
      nz_mask[i] = (CNT_W'(i) < n_loaded) && (mem[i].burst != '0);
  end

endmodule

// File: rtl/xbar_route_scheduler.sv
// Replays a programmed list of crossbar routes: issues each control word,
// counts the burst's beats on the routed path, then moves to the next route.
module xbar_route_scheduler
  import xbar_sched_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ENTRY_W-1:0]           cfg_msg,
  input  logic                         cfg_val,
  output logic                         cfg_rdy,
  input  logic                         clr,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  input  logic                         xfer_fire
);

  localparam int unsigned SRCH_W = IDX_W + 1;

  state_e                       state, state_n;
  logic [IDX_W-1:0]             idx, idx_n;
  logic [BURST_WIDTH-1:0]       beat_cnt, beat_n, beat_inc;
  logic [BURST_WIDTH-1:0]       cur_burst, cur_burst_n;
  logic [CONTROL_BIT_WIDTH-1:0] control_n;
  logic                         control_val_n, done_n, issue;
  logic [SRCH_W-1:0]            first_hit, next_hit;
  entry_t                       rd_data;
  logic [CNT_W-1:0]             n_loaded;
  logic [N_ENTRIES-1:0]         nz_mask;

  // Lowest usable entry at or above 'from'; MSB of the result flags a hit.
  function automatic logic [SRCH_W-1:0] find_from(
    input logic [N_ENTRIES-1:0] mask,
    input logic [SRCH_W-1:0]    from
  );
    logic [SRCH_W-1:0] r;
    r = '0;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--)
      if (mask[i] && (SRCH_W'(i) >= from)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  xbar_sched_table u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_val && cfg_rdy && !clr),
    .wr_data  (entry_t'(cfg_msg)),
    .clr      (clr && (state == ST_IDLE)),
    .rd_idx   (idx_n),
    .rd_data  (rd_data),
    .n_loaded (n_loaded),
    .nz_mask  (nz_mask)
  );

  assign cfg_rdy   = (state == ST_IDLE) && (n_loaded < CNT_W'(N_ENTRIES));
  assign first_hit = find_from(nz_mask, '0);
  assign next_hit  = find_from(nz_mask, SRCH_W'(idx) + SRCH_W'(1));
  assign beat_inc  = beat_cnt + BURST_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      beat_cnt    <= '0;
      cur_burst   <= '0;
      control     <= '0;
      control_val <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      beat_cnt    <= beat_n;
      cur_burst   <= cur_burst_n;
      control     <= control_n;
      control_val <= control_val_n;
      done        <= done_n;
      busy        <= (state_n != ST_IDLE);
    end
  end

  // Next state; the table is read at idx_n so the issued word registers with the transition.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    beat_n        = beat_cnt;
    cur_burst_n   = cur_burst;
    control_n     = control;
    control_val_n = control_val;
    done_n        = 1'b0;
    issue         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (first_hit[IDX_W]) begin
            state_n = ST_ISSUE;
            idx_n   = first_hit[IDX_W-1:0];
            issue   = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (control_rdy) begin
          state_n       = ST_COUNT;
          beat_n        = '0;
          control_val_n = 1'b0;
        end
      end
      ST_COUNT: begin
        if (xfer_fire) begin
          beat_n = beat_inc;
          if (beat_inc == cur_burst) begin
            if (next_hit[IDX_W]) begin
              state_n = ST_ISSUE;
              idx_n   = next_hit[IDX_W-1:0];
              issue   = 1'b1;
            end else begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (issue) begin
      control_val_n = 1'b1;
      control_n     = pack_control(rd_data.in_sel, rd_data.out_sel);
      cur_burst_n   = rd_data.burst;
    end
  end

endmodule

// File: tb/tb_xbar_route_scheduler.sv
// Directed bench for xbar_route_scheduler: hand-computed control words,
// beat counts and pass lengths for each scenario.
module tb_xbar_route_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  cfg_msg;
  logic        cfg_val, cfg_rdy, clr, start, busy, done;
  logic [41:0] control;
  logic        control_val, control_rdy, xfer_fire;

  int errors = 0;
  int checks = 0;

  int          hs_cnt = 0;
  int          beat_total = 0;
  logic [41:0] hs_word [64];

  localparam logic [41:0] W_I0_O0 = 42'h000_0000_0000;
  localparam logic [41:0] W_I0_O1 = 42'h100_0000_0000;
  localparam logic [41:0] W_I1_O0 = 42'h200_0000_0000;
  localparam logic [41:0] W_I1_O1 = 42'h300_0000_0000;

  xbar_route_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_msg     (cfg_msg),
    .cfg_val     (cfg_val),
    .cfg_rdy     (cfg_rdy),
    .clr         (clr),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .control     (control),
    .control_val (control_val),
    .control_rdy (control_rdy),
    .xfer_fire   (xfer_fire)
  );

  always #5 clk = ~clk;

  // Log every accepted control word and every beat seen while counting.
  always @(posedge clk) begin
    if (control_val && control_rdy) begin
      hs_word[hs_cnt % 64] <= control;
      hs_cnt               <= hs_cnt + 1;
    end
    if (busy && !control_val && xfer_fire) beat_total <= beat_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic i, input logic o, input logic [7:0] b);
    cfg_msg = {i, o, b};
    cfg_val = 1'b1;
    tick();
    cfg_val = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (control !== 42'h0) begin errors++; $display("FAIL reset_control: got %h want 0", control); end
    checks++; if ({control_val, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got val/busy/done=%b want 000", {control_val, busy, done}); end
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL reset_cfg_rdy: got %b want 1", cfg_rdy); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int hs0, bt0, cyc;
    bit seen;
    do_clr();
    load(1'b1, 1'b0, 8'd3);
    control_rdy = 1'b1;
    hs0 = hs_cnt; bt0 = beat_total;
    do_start();
    checks++; if ({control_val, busy} !== 2'b11) begin errors++; $display("FAIL single_issue: got val/busy=%b want 11", {control_val, busy}); end
    checks++; if (control !== W_I1_O0) begin errors++; $display("FAIL single_word: got %h want %h", control, W_I1_O0); end
    xfer_fire = 1'b1;
    wait_done(20, cyc, seen);
    xfer_fire = 1'b0;
    checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL single_len: got seen=%0d cyc=%0d want 1/4", seen, cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
    checks++; if (hs_cnt - hs0 != 1 || beat_total - bt0 != 3) begin errors++; $display("FAIL single_counts: got hs=%0d beats=%0d want 1/3", hs_cnt - hs0, beat_total - bt0); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_rdy_stall();
    int bt0;
    do_clr();
    load(1'b0, 1'b1, 8'd2);
    control_rdy = 1'b0;
    bt0 = beat_total;
    do_start();
    xfer_fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (control_val !== 1'b1 || control !== W_I0_O1) begin errors++; $display("FAIL stall_hold%0d: got val=%b word=%h want 1/%h", k, control_val, control, W_I0_O1); end
    end
    control_rdy = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stall_no_early_count: got busy=%b done=%b want 1/0", busy, done); end
    tick();
    xfer_fire = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_done: got done=%b busy=%b want 1/0", done, busy); end
    checks++; if (beat_total - bt0 != 2) begin errors++; $display("FAIL stall_beats: got %0d want 2", beat_total - bt0); end
    tick();
  endtask

  task automatic test_multi_skip();
    int hs0, bt0, cyc;
    bit seen;
    do_clr();
    load(1'b1, 1'b0, 8'd2);
    load(1'b1, 1'b1, 8'd0);
    load(1'b0, 1'b1, 8'd1);
    load(1'b1, 1'b1, 8'd3);
    control_rdy = 1'b1;
    hs0 = hs_cnt; bt0 = beat_total;
    do_start();
    xfer_fire = 1'b1;
    wait_done(40, cyc, seen);
    xfer_fire = 1'b0;
    checks++; if (!seen || cyc != 9) begin errors++; $display("FAIL multi_len: got seen=%0d cyc=%0d want 1/9", seen, cyc); end
    checks++; if (hs_cnt - hs0 != 3) begin errors++; $display("FAIL multi_words: got %0d want 3", hs_cnt - hs0); end
    checks++; if (beat_total - bt0 != 6) begin errors++; $display("FAIL multi_beats: got %0d want 6", beat_total - bt0); end
    checks++; if (hs_word[hs0 % 64] !== W_I1_O0 || hs_word[(hs0 + 1) % 64] !== W_I0_O1 || hs_word[(hs0 + 2) % 64] !== W_I1_O1) begin
      errors++; $display("FAIL multi_order: got %h %h %h want %h %h %h", hs_word[hs0 % 64], hs_word[(hs0 + 1) % 64], hs_word[(hs0 + 2) % 64], W_I1_O0, W_I0_O1, W_I1_O1);
    end
    tick();
  endtask

  task automatic test_full_and_clr();
    int hs0, bt0, cyc;
    bit seen;
    do_clr();
    load(1'b0, 1'b0, 8'd1);
    load(1'b1, 1'b0, 8'd1);
    load(1'b0, 1'b1, 8'd1);
    load(1'b1, 1'b1, 8'd1);
    checks++; if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL full_cfg_rdy: got %b want 0", cfg_rdy); end
    load(1'b1, 1'b1, 8'd7);
    control_rdy = 1'b1;
    hs0 = hs_cnt; bt0 = beat_total;
    do_start();
    xfer_fire = 1'b1;
    wait_done(40, cyc, seen);
    xfer_fire = 1'b0;
    checks++; if (!seen || cyc != 8 || hs_cnt - hs0 != 4 || beat_total - bt0 != 4) begin
      errors++; $display("FAIL full_pass: got seen=%0d cyc=%0d hs=%0d beats=%0d want 1/8/4/4", seen, cyc, hs_cnt - hs0, beat_total - bt0);
    end
    checks++; if (hs_word[hs0 % 64] !== W_I0_O0 || hs_word[(hs0 + 3) % 64] !== W_I1_O1) begin errors++; $display("FAIL full_words: got %h %h want %h %h", hs_word[hs0 % 64], hs_word[(hs0 + 3) % 64], W_I0_O0, W_I1_O1); end
    tick();
    // clr and cfg_val together: clear wins, the entry is dropped
    cfg_msg = {1'b0, 1'b1, 8'd4};
    cfg_val = 1'b1;
    clr     = 1'b1;
    tick();
    cfg_val = 1'b0;
    clr     = 1'b0;
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL clr_cfg_rdy: got %b want 1", cfg_rdy); end
    hs0 = hs_cnt;
    do_start();
    checks++; if ({done, busy, control_val} !== 3'b100) begin errors++; $display("FAIL empty_start: got done/busy/val=%b want 100", {done, busy, control_val}); end
    tick();
    checks++; if (done !== 1'b0 || hs_cnt != hs0) begin errors++; $display("FAIL empty_after: got done=%b hs=%0d want 0/0", done, hs_cnt - hs0); end
  endtask

  task automatic test_reset_mid_pass();
    int hs0;
    do_clr();
    load(1'b1, 1'b1, 8'd5);
    control_rdy = 1'b1;
    do_start();
    tick();
    xfer_fire = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({control_val, busy, done} !== 3'b000 || control !== 42'h0) begin errors++; $display("FAIL midreset_out: got val/busy/done=%b word=%h want 000/0", {control_val, busy, done}, control); end
    xfer_fire = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL midreset_cfg_rdy: got %b want 1", cfg_rdy); end
    hs0 = hs_cnt;
    do_start();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || hs_cnt != hs0) begin errors++; $display("FAIL midreset_cleared: got done=%b busy=%b hs=%0d want 1/0/0", done, busy, hs_cnt - hs0); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int hs0, bt0, cyc;
    bit seen;
    do_clr();
    load(1'b1, 1'b0, 8'd2);
    load(1'b0, 1'b1, 8'd2);
    control_rdy = 1'b1;
    hs0 = hs_cnt; bt0 = beat_total;
    do_start();
    start   = 1'b1;
    clr     = 1'b1;
    cfg_msg = {1'b1, 1'b1, 8'd9};
    cfg_val = 1'b1;
    xfer_fire = 1'b1;
    checks++; if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL busy_cfg_rdy: got %b want 0", cfg_rdy); end
    wait_done(30, cyc, seen);
    start = 1'b0; clr = 1'b0; cfg_val = 1'b0;
    checks++; if (!seen || cyc != 6 || hs_cnt - hs0 != 2 || beat_total - bt0 != 4) begin
      errors++; $display("FAIL busy_pass: got seen=%0d cyc=%0d hs=%0d beats=%0d want 1/6/2/4", seen, cyc, hs_cnt - hs0, beat_total - bt0);
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b want 0", busy); end
    // schedule survives the pass and is unchanged by the ignored clr/cfg_val
    hs0 = hs_cnt;
    do_start();
    wait_done(30, cyc, seen);
    xfer_fire = 1'b0;
    checks++; if (!seen || cyc != 6 || hs_cnt - hs0 != 2) begin errors++; $display("FAIL replay_pass: got seen=%0d cyc=%0d hs=%0d want 1/6/2", seen, cyc, hs_cnt - hs0); end
    checks++; if (hs_word[(hs0 + 1) % 64] !== W_I0_O1) begin errors++; $display("FAIL replay_word: got %h want %h", hs_word[(hs0 + 1) % 64], W_I0_O1); end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    cfg_msg = '0; cfg_val = 1'b0; clr = 1'b0; start = 1'b0;
    control_rdy = 1'b0; xfer_fire = 1'b0;
    test_reset();
    test_single();
    test_rdy_stall();
    test_multi_skip();
    test_full_and_clr();
    test_reset_mid_pass();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
